// File: rtl/testport_capture_fifo_if.sv
// Bus bundle for testport_capture_fifo: the DMEM write bus it snoops plus the
// valid/ready capture stream it serves to the result checker.
interface testport_capture_fifo_if;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] out_stamp;

  // Handshake: the head moves when out_valid & out_ready at posedge clk; out_valid
  // never depends on out_ready, and out_ready while out_valid is low does nothing.
  modport master (
    output addr, data, wen, out_ready,
    input  out_valid, out_data, out_last, out_stamp
  );

  modport slave (
    input  addr, data, wen, out_ready,
    output out_valid, out_data, out_last, out_stamp
  );
endinterface

// File: rtl/testport_capture_fifo.sv
// Captures test-port writes from the DMEM bus into a small FIFO for the checker.
// Optional macro TPCAP_CYCLE_STAMP_EN adds a per-entry 16-bit cycle stamp.
module testport_capture_fifo #(
  parameter logic [29:0] TEST_PORT    = 30'h10,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int          DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  testport_capture_fifo_if.slave bus,
  output logic                   started,
  output logic                   done,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          armed_q;
  logic [31:0]   swapped;
  logic          evt;
  logic          is_begin;
  logic          is_end;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [31:0]   mem_data [DEPTH];
  logic          mem_last [DEPTH];
  logic          empty, full;
  logic          pop, push_req, can_accept, push_ok, drop;
  logic          overflow_q;
  logic [7:0]    drop_cnt_q;

  // Bus words are little-endian; the checker wants the most significant byte first.
  assign swapped  = {bus.data[7:0], bus.data[15:8], bus.data[23:16], bus.data[31:24]};
  assign evt      = bus.wen & armed_q & (bus.addr == TEST_PORT);
  assign is_begin = (swapped == BEGIN_SYMBOL);
  assign is_end   = (swapped == END_SYMBOL);

  // A stalled store keeps wen high for several cycles; only its first cycle counts.
  always_ff @(posedge clk) begin
    if (!rst) armed_q <= 1'b1;
    else      armed_q <= ~bus.wen;
  end

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign pop        = ~empty & bus.out_ready;
  assign can_accept = ~full | pop;
  assign push_ok    = push_req & can_accept;
  assign drop       = push_req & ~can_accept;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt && is_begin) state_d = CAPT;
      end
      CAPT: begin
        if (evt) begin
          push_req = 1'b1;
          // A dropped end symbol leaves capture open.
          if (is_end && can_accept) state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        mem_data[wr_idx] <= swapped;
        mem_last[wr_idx] <= is_end;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

`ifdef TPCAP_CYCLE_STAMP_EN
  logic [15:0] stamp_q;
  logic [15:0] mem_stamp [DEPTH];

  // stamp_q + 1 is the number of cycles since the begin event at this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stamp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_stamp[i] <= '0;
    end else begin
      if (state_q == IDLE && state_d == CAPT) stamp_q <= '0;
      else if (state_q == CAPT)               stamp_q <= stamp_q + 16'd1;
      if (push_ok) mem_stamp[wr_idx] <= stamp_q + 16'd1;
    end
  end

  assign bus.out_stamp = mem_stamp[rd_idx];
`else
  assign bus.out_stamp = 16'h0000;
`endif

  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem_data[rd_idx];
  assign bus.out_last  = mem_last[rd_idx];

  assign started   = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_testport_capture_fifo.sv
// Self-checking bench for testport_capture_fifo: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_testport_capture_fifo;

  localparam logic [29:0] TP        = 30'h10;
  localparam logic [31:0] BEGIN_SYM = 32'h00000168;
  localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;
  localparam logic [31:0] BEGIN_BUS = 32'h68010000;
  localparam logic [31:0] END_BUS   = 32'h5DFDFFFF;
  localparam int          DEPTH     = 4;
`ifdef TPCAP_CYCLE_STAMP_EN
  localparam logic [15:0] STAMP_A = 16'd3;
  localparam logic [15:0] STAMP_B = 16'd10;
`else
  localparam logic [15:0] STAMP_A = 16'd0;
  localparam logic [15:0] STAMP_B = 16'd0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       started, done, overflow;
  logic [7:0] drop_cnt;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  testport_capture_fifo_if bus_if ();

  testport_capture_fifo #(
    .TEST_PORT(TP), .BEGIN_SYMBOL(BEGIN_SYM), .END_SYMBOL(END_SYM), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave),
    .started(started), .done(done), .overflow(overflow),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Entries packed as {stamp[15:0], last, data[31:0]}.
  logic [48:0] exp_q[$];
  int          m_phase   = 0;   // 0 waiting for begin, 1 capturing, 2 finished
  bit          m_armed   = 1'b1;
  bit          m_ovf     = 1'b0;
  int          m_drops   = 0;
  bit          m_fresh   = 1'b1;
  bit          model_ok  = 1'b0;
  int          cyc       = 0;
  int          begin_cyc = 0;
  logic [31:0] m_sw;
  bit          m_ev, m_pop, m_full;
  logic [15:0] m_stamp;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_phase  = 0;
      m_armed  = 1'b1;
      m_ovf    = 1'b0;
      m_drops  = 0;
      m_fresh  = 1'b1;
      model_ok = 1'b1;
    end else begin
      m_sw   = {bus_if.data[7:0], bus_if.data[15:8], bus_if.data[23:16], bus_if.data[31:24]};
      m_ev   = bus_if.wen && m_armed && (bus_if.addr == TP);
      m_pop  = (exp_q.size() != 0) && bus_if.out_ready;
      m_full = (exp_q.size() == DEPTH);
      if (m_pop) void'(exp_q.pop_front());
      if (m_ev) begin
        if (m_phase == 0) begin
          if (m_sw == BEGIN_SYM) begin
            m_phase   = 1;
            begin_cyc = cyc;
          end
        end else if (m_phase == 1) begin
          if (m_full && !m_pop) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
          end else begin
`ifdef TPCAP_CYCLE_STAMP_EN
            m_stamp = 16'(cyc - begin_cyc);
`else
            m_stamp = 16'h0;
`endif
            exp_q.push_back({m_stamp, (m_sw == END_SYM), m_sw});
            m_fresh = 1'b0;
            if (m_sw == END_SYM) m_phase = 2;
          end
        end
      end
      m_armed = !bus_if.wen;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("out_valid", 32'(bus_if.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", bus_if.out_data, exp_q[0][31:0]);
        chk("out_last", 32'(bus_if.out_last), 32'(exp_q[0][32]));
        chk("out_stamp", 32'(bus_if.out_stamp), 32'(exp_q[0][48:33]));
      end else if (m_fresh) begin
        chk("empty_data", bus_if.out_data, 32'h0);
        chk("empty_last_stamp", {15'h0, bus_if.out_last, bus_if.out_stamp}, 32'h0);
      end
      chk("started", 32'(started), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_word(input logic [29:0] a, input logic [31:0] d, input int hold);
    bus_if.addr = a;
    bus_if.data = d;
    bus_if.wen  = 1'b1;
    repeat (hold) tick();
    bus_if.wen  = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] d);
    write_word(TP, d, 1);
    idle(1);
  endtask

  task automatic pop_one();
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int hold_left;
  int sel;

  initial begin
    bus_if.addr      = '0;
    bus_if.data      = '0;
    bus_if.wen       = 1'b0;
    bus_if.out_ready = 1'b0;
    rst              = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);

    // reset state
    chk("rst_valid", 32'(bus_if.out_valid), 32'h0);
    chk("rst_data", bus_if.out_data, 32'h0);
    chk("rst_started", 32'(started), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // data before begin is filtered
    pulse(32'h34120000);
    chk("prebegin_valid", 32'(bus_if.out_valid), 32'h0);
    chk("prebegin_started", 32'(started), 32'h0);

    // handshake basics
    pulse(BEGIN_BUS);
    chk("hs_started", 32'(started), 32'h1);
    pulse(32'h34120000);
    pulse(END_BUS);
    chk("hs_head_data", bus_if.out_data, 32'h00001234);
    chk("hs_head_last", 32'(bus_if.out_last), 32'h0);
    pop_one();
    chk("hs_end_data", bus_if.out_data, 32'hFFFFFD5D);
    chk("hs_end_last", 32'(bus_if.out_last), 32'h1);
    chk("hs_done", 32'(done), 32'h1);
    pop_one();
    chk("hs_drained", 32'(bus_if.out_valid), 32'h0);

    // stall collapse
    do_reset();
    pulse(BEGIN_BUS);
    write_word(TP, 32'hCDAB0000, 5);
    idle(1);
    chk("stall_data", bus_if.out_data, 32'h0000ABCD);
    pop_one();
    chk("stall_single", 32'(bus_if.out_valid), 32'h0);
    write_word(30'h20, 32'h11111111, 1);
    write_word(TP, 32'h77000000, 1);
    idle(1);
    chk("stall_not_rearmed", 32'(bus_if.out_valid), 32'h0);

    // overflow with out_ready low
    do_reset();
    pulse(BEGIN_BUS);
    for (int i = 1; i <= 6; i++) pulse(32'(i) << 24);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_drops", 32'(drop_cnt), 32'h2);
    chk("ovf_head", bus_if.out_data, 32'h00000001);
    bus_if.addr      = TP;
    bus_if.data      = 32'h09000000;
    bus_if.wen       = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.wen       = 1'b0;
    bus_if.out_ready = 1'b0;
    chk("ovf_popped_push_drops", 32'(drop_cnt), 32'h2);
    chk("ovf_popped_push_head", bus_if.out_data, 32'h00000002);

    // reset mid-capture
    do_reset();
    pulse(BEGIN_BUS);
    for (int i = 0; i < 3; i++) pulse(32'hA0000000 + 32'(i));
    do_reset();
    chk("midrst_valid", 32'(bus_if.out_valid), 32'h0);
    chk("midrst_started", 32'(started), 32'h0);
    chk("midrst_overflow", 32'(overflow), 32'h0);
    pulse(32'h55000000);
    chk("midrst_idle", 32'(bus_if.out_valid), 32'h0);

    // cycle stamps: begin event at edge t, data at t+3 and t+10
    do_reset();
    idle(1);
    write_word(TP, BEGIN_BUS, 1);
    idle(2);
    write_word(TP, 32'h01000000, 1);
    idle(6);
    write_word(TP, 32'h02000000, 1);
    idle(1);
    chk("stamp_first", 32'(bus_if.out_stamp), 32'(STAMP_A));
    pop_one();
    chk("stamp_second", 32'(bus_if.out_stamp), 32'(STAMP_B));
    pop_one();

    // randomized traffic against the model
    do_reset();
    hold_left = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if (hold_left > 0) begin
        hold_left--;
      end else begin
        bus_if.wen  = ($urandom_range(0, 9) < 4);
        bus_if.addr = ($urandom_range(0, 3) != 0) ? TP : 30'($urandom);
        sel = $urandom_range(0, 9);
        bus_if.data = (sel < 2) ? BEGIN_BUS : (sel == 2) ? END_BUS : $urandom;
        hold_left = $urandom_range(0, 3);
      end
      bus_if.out_ready = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst              = 1'b1;
    bus_if.wen       = 1'b0;
    bus_if.out_ready = 1'b1;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/testport_capture_fifo.md
Name: testport_capture_fifo

Overview:
- Sits on the CPU-to-DMEM write bus, ahead of the result checker.
- Detects writes to the test-port word address and converts each little-endian bus word to readable byte order.
- Collapses writes that a D-cache stall holds for several cycles into one event, and frames the stream with begin/end symbols.
- Buffers captured words in a small FIFO; the checker drains it through a valid/ready handshake.

Parameters:
- TEST_PORT, 30'h10, word address of the test port.
- BEGIN_SYMBOL, 32'h00000168, readable-order word that starts capture; it is not enqueued.
- END_SYMBOL, 32'hFFFFFD5D, readable-order word that ends capture; it is enqueued.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst, input, 1, synchronous active-low reset, sampled on posedge clk.
- addr, input, 30, DMEM word address.
- data, input, 32, DMEM write data, little-endian byte order.
- wen, input, 1, DMEM write enable.
- out_valid, output, 1, FIFO head is valid.
- out_ready, input, 1, checker accepts the head this cycle.
- out_data, output, 32, FIFO head in readable order.
- out_last, output, 1, FIFO head is END_SYMBOL.
- out_stamp, output, 16, cycle stamp of the head (see Optional Feature).
- started, output, 1, begin symbol seen.
- done, output, 1, end symbol captured.
- overflow, output, 1, sticky: at least one word dropped because the FIFO was full.
- drop_cnt, output, 8, number of dropped words, saturating at 255.

Behaviour:
- Byte swap: swapped = {data[7:0], data[15:8], data[23:16], data[31:24]}.
- Stall collapse:
  - armed register, reset value 1.
  - Each cycle: armed_next = ~wen. Any wen clears armed, including writes to other addresses.
  - event = wen & armed & (addr == TEST_PORT).
  - A write held for N cycles produces exactly one event, in its first cycle.
- FSM states and transitions:
  - IDLE: on event with swapped == BEGIN_SYMBOL, go to CAPT and set started. Any other event is ignored.
  - CAPT: every event pushes {swapped, last = (swapped == END_SYMBOL)}. If last and the push is accepted, go to DONE and set done. A repeated BEGIN_SYMBOL in CAPT is an ordinary data word.
  - DONE: all events are ignored. FIFO draining continues. The block stays here until reset.
- FIFO:
  - Registered entries with read and write pointers of log2(DEPTH)+1 bits.
  - Empty when the pointers are equal; full when the MSBs differ and the lower bits are equal.
  - out_valid = ~empty. out_data, out_last and out_stamp come directly from the head entry (no extra read latency).
  - A word pushed on edge k is visible with out_valid = 1 after edge k, i.e. one cycle of latency.
  - Pop occurs when out_valid & out_ready.
  - Push when not full: accepted.
  - Push when full with no pop in the same cycle: word dropped; overflow set; drop_cnt incremented (saturating).
  - Push when full with a pop in the same cycle: accepted; occupancy unchanged.
  - Push and pop together when not full: both occur.
  - A dropped END_SYMBOL does not move the FSM to DONE; the block stays in CAPT.
  - Pointers wrap modulo 2*DEPTH.
- Reset (rst low at posedge):
  - FSM to IDLE, FIFO emptied, armed = 1.
  - started = 0, done = 0, overflow = 0, drop_cnt = 0, out_valid = 0.
  - out_data, out_last and out_stamp read 0 while the FIFO is empty after reset.
  - Reset mid-capture discards every buffered word.
- out_ready while out_valid = 0 has no effect.

Optional Feature:
- Macro: TPCAP_CYCLE_STAMP_EN.
- Defined:
  - A 16-bit counter clears on the transition to CAPT, increments each cycle in CAPT, and freezes in DONE; it wraps at 16'hFFFF.
  - Each entry stores the counter value at its push; out_stamp presents the head's stamp.
- Undefined: no counter and no stamp storage; out_stamp is tied to 16'h0000.

Test Plan:
- Handshake basics:
  - Stimulus: wen pulses at TEST_PORT carrying bus words 32'h68010000 (begin), then 32'h34120000, then 32'h5D FD FF FF.
  - Required: started = 1; two pops yield 32'h00001234 with last = 0, then 32'hFFFFFD5D with last = 1; done = 1.
- Stall collapse:
  - Stimulus: in CAPT, hold wen = 1 for 5 cycles with data 32'hCDAB0000.
  - Required: exactly one entry, 32'h0000ABCD.
  - Stimulus: then a wen pulse to addr 30'h20, followed with no gap by a write to TEST_PORT.
  - Required: no entry for the TEST_PORT write (armed not restored).
- Pre-begin filtering:
  - Stimulus: in IDLE, write 32'h34120000 to TEST_PORT.
  - Required: FIFO stays empty and started = 0.
- Overflow, DEPTH = 4, out_ready = 0:
  - Stimulus: after begin, 6 separate data writes.
  - Required: 4 entries held; overflow = 1; drop_cnt = 2.
  - Stimulus: a push on the same cycle as a pop while full.
  - Required: push accepted; drop_cnt stays 2.
- Reset mid-capture:
  - Stimulus: 3 entries buffered, drive rst = 0 for 1 cycle.
  - Required: out_valid = 0, started = 0, overflow = 0; FSM back in IDLE (a data write is ignored until the next begin).
- Stamp check (TPCAP_CYCLE_STAMP_EN defined):
  - Stimulus: begin event at cycle t; data writes at t+3 and t+10.
  - Required: stamps 3 and 10. With the macro undefined, out_stamp = 0.
